// File: rtl/playseq_pkg.sv
// playseq_pkg: state encoding and timing constants shared by the play-sequence control unit
package playseq_pkg;
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA_LED  = 4'h2,
    MOSTRA_GAP  = 4'h3,
    PROX_MOSTRA = 4'h4,
    ESPERA      = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    PROX_JOGADA = 4'h8,
    FIM_RODADA  = 4'h9,
    NOVA_RODADA = 4'hA,
    GANHOU      = 4'hB,
    PERDEU      = 4'hC
  } estado_t;
  localparam int TIMEOUT_STEP_S = 5;
  localparam logic [3:0] LIMITE_MAX = 4'd15;
endpackage

// File: rtl/playseq_timer.sv
// playseq_timer: up-counter with clear/enable and a terminal-count compare
module playseq_timer #(
  parameter int TW = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] fim,
  output logic          done
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clock)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + TW'(1);
  assign done = cnt == fim;
endmodule

// File: rtl/playseq_unidade_controle.sv
// playseq_unidade_controle: round sequencer of the play-sequence game (show, collect, grow, win/lose)
module playseq_unidade_controle
  import playseq_pkg::*;
#(
  parameter int CLK_HZ   = 50000,
  parameter int T_LED_MS = 500,
  parameter int T_GAP_MS = 500,
  parameter int TW       = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [1:0] nivel,
  input  logic [1:0] timeoutD,
  input  logic       ignora_timeout,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_end,
  output logic       zera_end,
  output logic       conta_end,
  output logic       registra,
  output logic       mostra,
  output logic [3:0] limite,
  output logic       ganhou,
  output logic       perdeu,
  output logic       conta_vitoria,
  output logic       conta_derrota,
  output logic       db_timeout,
  output logic [3:0] db_estado
);
  // terminal counts are duration-1 because the timer starts at 0 on state entry
  localparam logic [TW-1:0] T_LED = TW'(CLK_HZ * T_LED_MS / 1000 - 1);
  localparam logic [TW-1:0] T_GAP = TW'(CLK_HZ * T_GAP_MS / 1000 - 1);
  localparam logic [TW-1:0] STEP  = TW'(TIMEOUT_STEP_S * CLK_HZ);
  estado_t estado, prox;
  logic jogar_d, rise, done, expira, clr;
  logic [1:0] nivel_lat, td_lat;
  logic [TW-1:0] fim;
  logic [4:0] soma;
  assign rise   = jogar & ~jogar_d;
  assign fim    = estado == MOSTRA_LED ? T_LED :
                  estado == MOSTRA_GAP ? T_GAP : STEP * (TW'(td_lat) + TW'(1)) - TW'(1);
  assign expira = done & ~ignora_timeout;
  assign clr    = prox != estado || (estado == ESPERA && ignora_timeout);
  assign soma   = {1'b0, limite} + {3'b0, nivel_lat} + 5'd1;
  playseq_timer #(.TW(TW)) u_timer (
    .clock(clock),
    .reset(reset),
    .clr  (clr),
    .en   (1'b1),
    .fim  (fim),
    .done (done)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= INICIAL;
      jogar_d       <= 1'b0;
      limite        <= '0;
      nivel_lat     <= '0;
      td_lat        <= '0;
      db_timeout    <= 1'b0;
      conta_vitoria <= 1'b0;
      conta_derrota <= 1'b0;
    end else begin
      estado        <= prox;
      jogar_d       <= jogar;
      conta_vitoria <= prox == GANHOU && estado != GANHOU;
      conta_derrota <= prox == PERDEU && estado != PERDEU;
      if (estado == PREPARA) begin
        nivel_lat  <= nivel;
        td_lat     <= timeoutD;
        limite     <= {2'b0, nivel};
        db_timeout <= 1'b0;
      end
      if (estado == NOVA_RODADA) limite <= soma > 5'd15 ? LIMITE_MAX : soma[3:0];
      if (estado == ESPERA && !jogada && expira) db_timeout <= 1'b1;
    end
  end
  always_comb begin
    prox      = estado;
    zera_end  = 1'b0;
    conta_end = 1'b0;
    registra  = 1'b0;
    mostra    = 1'b0;
    case (estado)
      INICIAL, GANHOU, PERDEU: prox = rise ? PREPARA : estado;
      PREPARA: begin
        zera_end = 1'b1;
        prox     = MOSTRA_LED;
      end
      MOSTRA_LED: begin
        mostra = 1'b1;
        prox   = done ? MOSTRA_GAP : estado;
      end
      MOSTRA_GAP: begin
        zera_end = done & fim_end;
        prox     = !done ? estado : fim_end ? ESPERA : PROX_MOSTRA;
      end
      PROX_MOSTRA: begin
        conta_end = 1'b1;
        prox      = MOSTRA_LED;
      end
      ESPERA: prox = jogada ? REGISTRA : expira ? PERDEU : estado;
      REGISTRA: begin
        registra = 1'b1;
        prox     = COMPARA;
      end
      COMPARA: prox = !igual ? PERDEU : fim_end ? FIM_RODADA : PROX_JOGADA;
      PROX_JOGADA: begin
        conta_end = 1'b1;
        prox      = ESPERA;
      end
      FIM_RODADA: prox = limite == LIMITE_MAX ? GANHOU : NOVA_RODADA;
      NOVA_RODADA: begin
        zera_end = 1'b1;
        prox     = MOSTRA_LED;
      end
      default: prox = INICIAL;
    endcase
  end
  assign ganhou    = estado == GANHOU;
  assign perdeu    = estado == PERDEU;
  assign db_estado = estado;
endmodule

// File: tb/tb_playseq_unidade_controle.sv
// tb_playseq_unidade_controle: randomized games against a round-level model of the control unit
module tb_playseq_unidade_controle;
  localparam int T_LED = 10;
  localparam int T_GAP = 10;
  logic clock = 0, reset = 1, jogar = 0, jogada = 0, ignora_timeout = 0;
  logic [1:0] nivel = 0, timeoutD = 0;
  logic igual, fim_end;
  logic zera_end, conta_end, registra, mostra, ganhou, perdeu;
  logic conta_vitoria, conta_derrota, db_timeout;
  logic [3:0] limite, db_estado;
  logic [3:0] addr = 0, play_reg = 0, btn = 0;
  logic [3:0] mem [16];
  int checks = 0, failures = 0, vit_pulses = 0, der_pulses = 0;
  always #5 clock = ~clock;
  playseq_unidade_controle #(.CLK_HZ(1000), .T_LED_MS(10), .T_GAP_MS(10), .TW(24)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel), .timeoutD(timeoutD),
    .ignora_timeout(ignora_timeout), .jogada(jogada), .igual(igual), .fim_end(fim_end),
    .zera_end(zera_end), .conta_end(conta_end), .registra(registra), .mostra(mostra),
    .limite(limite), .ganhou(ganhou), .perdeu(perdeu), .conta_vitoria(conta_vitoria),
    .conta_derrota(conta_derrota), .db_timeout(db_timeout), .db_estado(db_estado)
  );
  // datapath stand-in: address counter, play register, sequence memory
  assign fim_end = addr == limite;
  assign igual   = play_reg == mem[addr];
  always @(posedge clock) begin
    if (zera_end) addr <= 0;
    else if (conta_end) addr <= addr + 1;
    if (registra) play_reg <= btn;
    if (conta_vitoria) vit_pulses <= vit_pulses + 1;
    if (conta_derrota) der_pulses <= der_pulses + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_st(input logic [3:0] s, input int budget, input string tag);
    int n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, db_estado, s);
  endtask
  task automatic start(input logic [1:0] nv, input logic [1:0] td);
    nivel = nv;
    timeoutD = td;
    jogar = 1;
    @(negedge clock);
    jogar = 0;
    chk("prepara", db_estado, 4'h1);
    @(negedge clock);
    chk("limite_ini", limite, {2'b0, nv});
    chk("ganhou_clr", ganhou, 0);
    chk("perdeu_clr", perdeu, 0);
    chk("tmo_clr", db_timeout, 0);
  endtask
  task automatic game(input logic [1:0] nv, input int bad_r, input int bad_j);
    int lim, n, v0, d0;
    for (int k = 0; k < 16; k++) mem[k] = 4'($urandom);
    v0 = vit_pulses;
    d0 = der_pulses;
    start(nv, 2'd0);
    lim = nv;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i <= lim; i++) begin
        n = 0;
        while (!mostra && n < 40) begin
          @(negedge clock);
          n++;
        end
        chk("led_addr", addr, i);
        n = 0;
        while (mostra && n < 40) begin
          @(negedge clock);
          n++;
        end
        chk("led_len", n, T_LED);
        n = 0;
        btn = ~mem[0];
        while (db_estado == 4'h3 && n < 40) begin
          jogada = r == 0 && i == 0 && n == 0;
          @(negedge clock);
          n++;
        end
        jogada = 0;
        chk("gap_len", n, T_GAP);
      end
      wait_st(4'h5, 10, "espera");
      if (r == 0) begin
        jogar = 1;
        @(negedge clock);
        jogar = 0;
        chk("jogar_ign", db_estado, 4'h5);
      end
      for (int j = 0; j <= lim; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        btn = (r == bad_r && j == bad_j) ? ~mem[j] : mem[j];
        jogada = 1;
        @(negedge clock);
        jogada = 0;
        if (r == bad_r && j == bad_j) begin
          wait_st(4'hC, 10, "perde");
          repeat (3) @(negedge clock);
          chk("perdeu", perdeu, 1);
          chk("tmo_no", db_timeout, 0);
          chk("ganhou_no", ganhou, 0);
          chk("derrota_pulse", der_pulses - d0, 1);
          return;
        end
        if (j < lim) wait_st(4'h5, 10, "espera_j");
      end
      if (lim == 15) begin
        wait_st(4'hB, 10, "ganha");
        repeat (3) @(negedge clock);
        chk("ganhou", ganhou, 1);
        chk("perdeu_no", perdeu, 0);
        chk("vitoria_pulse", vit_pulses - v0, 1);
        return;
      end
      lim = lim + nv + 1 > 15 ? 15 : lim + nv + 1;
      wait_st(4'h2, 10, "nova");
      chk("limite", limite, lim);
    end
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clock);
    chk("rst_estado", db_estado, 0);
    chk("rst_limite", limite, 0);
    chk("rst_outs", {zera_end, conta_end, registra, mostra, ganhou, perdeu,
                     conta_vitoria, conta_derrota, db_timeout}, 0);
    reset = 0;
    @(negedge clock);
    game(2'd1, -1, -1);
    game(2'd3, -1, -1);
    game(2'd2, -1, -1);
    game(2'($urandom_range(1, 3)), 1, 2);
    start(2'd0, 2'd1);
    wait_st(4'h5, 60, "espera_t");
    n = 0;
    while (db_estado == 4'h5 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_len", n, 10000);
    chk("tmo_estado", db_estado, 4'hC);
    chk("db_timeout", db_timeout, 1);
    chk("tmo_perdeu", perdeu, 1);
    ignora_timeout = 1;
    start(2'd0, 2'd1);
    wait_st(4'h5, 60, "espera_i");
    repeat (12500) @(negedge clock);
    chk("ignora", db_estado, 4'h5);
    ignora_timeout = 0;
    n = 0;
    while (db_estado == 4'h5 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("ignora_len", n, 10000);
    chk("ignora_tmo", db_timeout, 1);
    start(2'd2, 2'd0);
    repeat (25) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("mid_estado", db_estado, 0);
    chk("mid_limite", limite, 0);
    chk("mid_mostra", mostra, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
